ervp_spio_regbank: RTL and testbench
====================================

# ervp_spio_regbank

Parametrised special-purpose IO register bank on the external peripheral group's APB-style slave port. It replaces hand-instantiated per-signal registers with NUM_CH uniform channels. Each channel has a compile-time mode: read/write control, synchronised read-only status, self-clearing write pulse, or sticky edge-captured pending with write-1-to-clear. It also aggregates a maskable interrupt. It sits between the peripheral-group APB decoder and board-level control/status pins (OLED, WiFi, SPI select, serial control).

## Interface
Parameters
- BW_ADDR, 8: APB address width; word index = paddr[BW_ADDR-1:2].
- BW_DATA, 32: APB data width.
- NUM_CH, 8: channel count, 1..32; requires NUM_CH+2 ≤ 2^(BW_ADDR-2).
- REG_BW, 4: channel register width, 1..BW_DATA.
- CH_MODE, 0: NUM_CH×2 bits; channel k at [2k+1:2k].
  - 0 = RW, 1 = RO, 2 = PULSE, 3 = PEND.
- CH_RESET, 0: NUM_CH×REG_BW bits; reset value of RW registers; ignored for other modes.

Ports
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  1 = write.
- paddr  in  BW_ADDR  byte address.
- pwdata  in  BW_DATA  write data.
- prdata  out  BW_DATA  read data, zero-extended.
- pready  out  1  constant 1.
- pslverr  out  1  error on unmapped index.
- ch_in  in  NUM_CH×REG_BW  asynchronous status inputs, used by RO/PEND channels.
- ch_out  out  NUM_CH×REG_BW  channel outputs.
- ch_pulse  out  NUM_CH  one-cycle write strobe per PULSE channel.
- irq  out  1  registered interrupt.

## Operation
- Access = psel & penable. Write = access & pwrite. Read = access & ~pwrite.
- Index map:
  - 0..NUM_CH-1 → channels.
  - NUM_CH → IRQ_EN (NUM_CH bits, RW).
  - NUM_CH+1 → IRQ_STAT (RO, = pend_any & IRQ_EN).
  - Any other index → pslverr=1 during access. Writes are ignored; prdata=0.
- Decode uses full word index; paddr[1:0] ignored. pwdata bits above REG_BW are ignored.
- Input synchroniser: ch_in passes through two flops → s2, with a third flop s3 for edge detect. All three are cleared by rst.
- RW: reg ← pwdata[REG_BW-1:0] on write. ch_out = reg. Read returns reg.
- RO: writes ignored. Read returns s2. ch_out = 0.
- PULSE:
  - On write: pulse reg ← pwdata and ch_pulse[k] ← 1, both for exactly one cycle, then cleared.
  - Read returns 0. ch_out = pulse reg (zero when idle).
- PEND:
  - pend[b] ← 1 on s2[b] & ~s3[b].
  - A write clears bits where pwdata[b]=1.
  - Simultaneous set and clear on the same bit: set wins.
  - Read returns pend. ch_out = 0.
- pend_any[k] = |pend (PEND channels only; 0 otherwise).
- irq ← |(pend_any & IRQ_EN), registered.
- Reset values:
  - RW regs = CH_RESET slice; all other regs 0.
  - IRQ_EN = 0; ch_pulse = 0; irq = 0; ch_out = RW reset values / 0; sync flops = 0.
  - No edge is detected on the first cycles after reset unless ch_in is actually high: s2 rises 0→1 after reset, and that counts as an edge.

## Timing
- Zero wait states; pready = 1 always. prdata and pslverr are combinational from the current address and registers.
- Write lands on the clk edge ending the access cycle; ch_out/ch_pulse are visible the next cycle.
- ch_in to RO read value: 2 clk latency.
- ch_in rising to pend set: 3 clk; to irq: 4 clk.
- W1C write to irq deassert: 2 clk, if no new edge arrives.
- Back-to-back PULSE writes in consecutive cycles produce consecutive ch_pulse cycles, with no merging.
- A write with psel=1 and penable=0 (setup phase) has no effect.
- rst asserted mid-operation: the next edge restores all reset values. An access in the same cycle is discarded.

## Test plan
- Reset, NUM_CH=4, REG_BW=4, CH_MODE=ch0 RW / ch1 RO / ch2 PULSE / ch3 PEND, CH_RESET ch0=4'hA → read idx0 = 0xA, idx3 = 0, irq=0, ch_pulse=0.
- Write 0x5 to idx0 → ch_out[3:0]=5 the next cycle. Write 0x3 to idx1 → ignored; read idx1 tracks ch_in[7:4]=0x6 after 2 clk.
- Write 0x9 to idx2 on two consecutive cycles → ch_pulse[2]=1 for 2 cycles, ch_out[11:8]=9, then 0. Read idx2 = 0.
- Write IRQ_EN=0x8, then raise ch_in[12] → pend=0x1 after 3 clk, irq=1 after 4 clk, IRQ_STAT=0x8. Write 0x1 to idx3 → irq=0 two clk later.
- Hold a new rising edge on ch_in[13] in the same cycle as W1C of bit1 → bit1 stays 1 (set wins). Bit0 is cleared.
- Access idx 7 → pslverr=1, prdata=0, no state change. Assert rst during a write to idx0 → idx0 reads 0xA.

Source files
------------

// File: rtl/ervp_spio_regbank.sv
// Special-purpose IO register bank on an APB-style slave port: NUM_CH channels, each fixed at
// build time as RW control, synchronised RO status, write pulse, or sticky W1C pending.
module ervp_spio_ch #(
    parameter int                REG_BW  = 4,
    parameter logic [1:0]        MODE    = 2'd0,
    parameter logic [REG_BW-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [REG_BW-1:0] wdata,
    input  logic [REG_BW-1:0] s2,
    input  logic [REG_BW-1:0] s3,
    output logic [REG_BW-1:0] rdata,
    output logic [REG_BW-1:0] ch_out,
    output logic              pulse,
    output logic              pend_any
);
    logic [REG_BW-1:0] reg_q, reg_d;
    logic              pulse_q, pulse_d;

    always_comb begin
        reg_d   = reg_q;
        pulse_d = 1'b0;
        rdata   = '0;
        ch_out  = '0;
        case (MODE)
            2'd0: begin
                if (wr) reg_d = wdata;
                rdata  = reg_q;
                ch_out = reg_q;
            end
            2'd1: begin
                reg_d = '0;
                rdata = s2;
            end
            2'd2: begin
                reg_d   = wr ? wdata : '0;
                pulse_d = wr;
                ch_out  = reg_q;
            end
            default: begin
                // New edge is OR-ed in after the clear so a coincident set survives.
                reg_d = (reg_q & ~(wr ? wdata : '0)) | (s2 & ~s3);
                rdata = reg_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_q   <= (MODE == 2'd0) ? RST_VAL : '0;
            pulse_q <= 1'b0;
        end else begin
            reg_q   <= reg_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse    = pulse_q;
    assign pend_any = (MODE == 2'd3) & (|reg_q);
endmodule

module ervp_spio_regbank #(
    parameter int                         BW_ADDR  = 8,
    parameter int                         BW_DATA  = 32,
    parameter int                         NUM_CH   = 8,
    parameter int                         REG_BW   = 4,
    parameter logic [2*NUM_CH-1:0]        CH_MODE  = '0,
    parameter logic [NUM_CH*REG_BW-1:0]   CH_RESET = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [BW_ADDR-1:0]         paddr,
    input  logic [BW_DATA-1:0]         pwdata,
    output logic [BW_DATA-1:0]         prdata,
    output logic                       pready,
    output logic                       pslverr,
    input  logic [NUM_CH*REG_BW-1:0]   ch_in,
    output logic [NUM_CH*REG_BW-1:0]   ch_out,
    output logic [NUM_CH-1:0]          ch_pulse,
    output logic                       irq
);
    localparam int IDX_W = BW_ADDR - 2;

    logic [IDX_W-1:0]               idx;
    logic                           access, wr_en, mapped;
    logic [NUM_CH*REG_BW-1:0]       s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [NUM_CH-1:0]              irq_en_q, irq_en_d, pend_any;
    logic                           irq_q, irq_d;
    logic [NUM_CH-1:0][REG_BW-1:0]  ch_rdata;
    logic                           unused_bits;

    assign idx         = paddr[BW_ADDR-1:2];
    assign access      = psel & penable;
    assign wr_en       = access & pwrite;
    assign pready      = 1'b1;
    assign unused_bits = ^{paddr[1:0], pwdata};

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        ervp_spio_ch #(
            .REG_BW  (REG_BW),
            .MODE    (CH_MODE[2*k +: 2]),
            .RST_VAL (CH_RESET[k*REG_BW +: REG_BW])
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .wr       (wr_en && (idx == IDX_W'(k))),
            .wdata    (pwdata[REG_BW-1:0]),
            .s2       (s2_q[k*REG_BW +: REG_BW]),
            .s3       (s3_q[k*REG_BW +: REG_BW]),
            .rdata    (ch_rdata[k]),
            .ch_out   (ch_out[k*REG_BW +: REG_BW]),
            .pulse    (ch_pulse[k]),
            .pend_any (pend_any[k])
        );
    end

    always_comb begin
        prdata = '0;
        mapped = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx == IDX_W'(k)) begin
                prdata = BW_DATA'(ch_rdata[k]);
                mapped = 1'b1;
            end
        end
        if (idx == IDX_W'(NUM_CH)) begin
            prdata = BW_DATA'(irq_en_q);
            mapped = 1'b1;
        end
        if (idx == IDX_W'(NUM_CH + 1)) begin
            prdata = BW_DATA'(pend_any & irq_en_q);
            mapped = 1'b1;
        end
    end

    assign pslverr = access & ~mapped;

    always_comb begin
        s1_d     = ch_in;
        s2_d     = s1_q;
        s3_d     = s2_q;
        irq_en_d = (wr_en && idx == IDX_W'(NUM_CH)) ? pwdata[NUM_CH-1:0] : irq_en_q;
        irq_d    = |(pend_any & irq_en_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;
endmodule

// File: tb/tb_ervp_spio_regbank.sv
// Directed bench for ervp_spio_regbank: ch0 RW (reset 0xA), ch1 RO, ch2 PULSE, ch3 PEND.
module tb_ervp_spio_regbank;
    logic        clk = 1'b0;
    logic        rst, psel, penable, pwrite, pready, pslverr, irq;
    logic [7:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic [15:0] ch_in, ch_out;
    logic [3:0]  ch_pulse;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t    sb_q[$];
    int          npass = 0;
    int          nfail = 0;
    logic [31:0] rdv;
    logic        errv;

    ervp_spio_regbank #(
        .BW_ADDR(8), .BW_DATA(32), .NUM_CH(4), .REG_BW(4),
        .CH_MODE(8'hE4), .CH_RESET(16'h000A)
    ) dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .ch_in(ch_in), .ch_out(ch_out), .ch_pulse(ch_pulse), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic ex(input string tag, input logic [31:0] e);
        sb_item_t it;
        it.tag = tag;
        it.exp = e;
        sb_q.push_back(it);
    endtask

    task automatic chk(input logic [31:0] obs);
        sb_item_t it;
        if (sb_q.size() == 0) begin
            nfail++;
            $display("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
        end else begin
            it = sb_q.pop_front();
            assert (obs === it.exp) npass++;
            else begin
                nfail++;
                $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic idle();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input int idx, input logic [31:0] d);
        @(negedge clk);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
        paddr = 8'(idx << 2); pwdata = d;
        @(negedge clk);
        idle();
    endtask

    task automatic rd(input int idx);
        @(negedge clk);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0;
        paddr = 8'(idx << 2);
        #1;
        rdv  = prdata;
        errv = pslverr;
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ch_in = '0; paddr = '0; pwdata = '0;
        idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        ex("rst_idx0", 32'hA);      rd(0); chk(rdv);
        ex("rst_idx3", 32'h0);      rd(3); chk(rdv);
        ex("rst_irq", 32'h0);       chk(32'(irq));
        ex("rst_pulse", 32'h0);     chk(32'(ch_pulse));
        ex("rst_ch_out", 32'h000A); chk(32'(ch_out));
        ex("pready", 32'h1);        chk(32'(pready));

        // RW channel
        wr(0, 32'hFFFF_FFF5);
        ex("rw_ch_out", 32'h5);     chk(32'(ch_out[3:0]));
        ex("rw_read", 32'h5);       rd(0); chk(rdv);

        // RO channel: write ignored, 2-clk sync latency
        wr(1, 32'h3);
        @(negedge clk); ch_in = 16'h0060;
        ex("ro_lat1", 32'h0);       rd(1); chk(rdv);
        ex("ro_lat2", 32'h6);       rd(1); chk(rdv);
        ex("ro_ch_out", 32'h0);     chk(32'(ch_out[7:4]));

        // PULSE channel, back-to-back writes
        @(negedge clk);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'h9;
        @(negedge clk);
        ex("pulse_c1", 32'h4);      chk(32'(ch_pulse));
        ex("pulse_out1", 32'h9);    chk(32'(ch_out[11:8]));
        @(negedge clk); idle();
        ex("pulse_c2", 32'h4);      chk(32'(ch_pulse));
        ex("pulse_out2", 32'h9);    chk(32'(ch_out[11:8]));
        @(negedge clk);
        ex("pulse_c3", 32'h0);      chk(32'(ch_pulse));
        ex("pulse_out3", 32'h0);    chk(32'(ch_out[11:8]));
        ex("pulse_read", 32'h0);    rd(2); chk(rdv);

        // PEND + IRQ
        wr(4, 32'h8);
        ex("irq_en", 32'h8);        rd(4); chk(rdv);
        @(negedge clk); ch_in = 16'h1060;
        ex("pend_t1", 32'h0);       rd(3); chk(rdv);
        ex("pend_t2", 32'h0);       rd(3); chk(rdv);
        ex("pend_t3", 32'h1);       rd(3); chk(rdv);
        ex("irq_t3", 32'h0);        chk(32'(irq));
        @(negedge clk);
        ex("irq_t4", 32'h1);        chk(32'(irq));
        ex("irq_stat", 32'h8);      rd(5); chk(rdv);
        wr(3, 32'h1);
        ex("w1c_irq_t1", 32'h1);    chk(32'(irq));
        @(negedge clk);
        ex("w1c_irq_t2", 32'h0);    chk(32'(irq));
        ex("w1c_pend", 32'h0);      rd(3); chk(rdv);

        // Set wins over coincident W1C
        @(negedge clk); ch_in = 16'h0060;
        repeat (3) @(negedge clk);
        ch_in = 16'h1060;
        repeat (4) @(negedge clk);
        ex("pend_rearm", 32'h1);    rd(3); chk(rdv);
        @(negedge clk); ch_in = 16'h3060;
        @(negedge clk);
        wr(3, 32'h3);
        ex("set_wins", 32'h2);      rd(3); chk(rdv);
        ex("set_wins_irq", 32'h1);  chk(32'(irq));

        // Unmapped index, setup-only write
        ex("unmap_data", 32'h0);    rd(7); chk(rdv);
        ex("unmap_err", 32'h1);     chk(32'(errv));
        wr(7, 32'hF);
        ex("mapped_err", 32'h0);    rd(0); chk(32'(errv));
        ex("unmap_noeff0", 32'h5);  chk(rdv);
        ex("unmap_noeff4", 32'h8);  rd(4); chk(rdv);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h7;
        @(negedge clk); idle();
        ex("setup_noeff", 32'h5);   rd(0); chk(rdv);

        // Reset during a write
        @(negedge clk);
        rst = 1'b1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'hF;
        @(negedge clk);
        rst = 1'b0; idle();
        ex("rst_mid_idx0", 32'hA);  rd(0); chk(rdv);
        ex("rst_mid_pend", 32'h0);  rd(3); chk(rdv);
        ex("rst_mid_en", 32'h0);    rd(4); chk(rdv);
        ex("rst_mid_irq", 32'h0);   chk(32'(irq));
        ex("post_rst_edge", 32'h3); rd(3); chk(rdv);

        $display("%0d/%0d checks passed", npass, npass + nfail);
        $finish;
    end
endmodule
